// File: rtl/stopwatch_pkg.sv
// Shared types and default sizing for the stopwatch run/pause/lap controller.
// The state encoding is fixed at 2 bits so the state can be probed directly.
package stopwatch_pkg;

    localparam int DEF_CNT_W   = 14;
    localparam int DEF_CNT_MAX = 9999;
    localparam int DEF_DEB_CNT = 1000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter, debounced level,
// and a one-cycle event on each accepted press. Releases produce no event.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEB_CNT = DEF_DEB_CNT
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_btn,
    output logic o_ev
);

    localparam int             CW      = $clog2(DEB_CNT + 1);
    localparam logic [CW-1:0]  CNT_TOP = CW'(DEB_CNT);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_ev;
    logic [CW-1:0] r_cnt;

    // The counter only runs while the synchronised input disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_ev      <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_TOP) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_ev      <= r_level & ~r_level_d;
        end
    end

    assign o_ev = r_ev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: debounced start/stop and lap/reset buttons drive a
// 4-state FSM that gates counting, clears the counter and freezes lap values.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEB_CNT = DEF_DEB_CNT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int CNT_MAX = DEF_CNT_MAX
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_btn_ss,
    input  logic             i_btn_lap,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_cnt_q,
    output logic             o_cnt_ce,
    output logic             o_cnt_clr,
    output logic [CNT_W-1:0] o_disp_q,
    output logic             o_run_led,
    output logic             o_lap_led,
    output logic             o_ovf
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

    state_t           r_state;
    logic [CNT_W-1:0] r_hold;
    logic             r_ovf;
    logic             r_clr_pulse;
    logic             w_ss_ev;
    logic             w_lap_ev;
    logic             w_running;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_ss (
        .i_clk (i_clk),
        .i_clr (i_clr),
        .i_btn (i_btn_ss),
        .o_ev  (w_ss_ev)
    );

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_lap (
        .i_clk (i_clk),
        .i_clr (i_clr),
        .i_btn (i_btn_lap),
        .o_ev  (w_lap_ev)
    );

    assign w_running = (r_state == RUN) || (r_state == LAP);

    // Start/stop is tested first in every state, so a simultaneous lap press is dropped.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_ovf       <= 1'b0;
            r_clr_pulse <= 1'b0;
        end else begin
            r_clr_pulse <= 1'b0;
            if (o_cnt_ce && (i_cnt_q == CNT_TOP)) begin
                r_ovf <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_ss_ev) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_ss_ev) begin
                        r_state <= PAUSE;
                    end else if (w_lap_ev) begin
                        r_state <= LAP;
                        r_hold  <= i_cnt_q;
                    end
                end
                LAP: begin
                    if (w_ss_ev) begin
                        r_state <= PAUSE;
                    end else if (w_lap_ev) begin
                        r_state <= RUN;
                    end
                end
                PAUSE: begin
                    if (w_ss_ev) begin
                        r_state <= RUN;
                    end else if (w_lap_ev) begin
                        r_state     <= IDLE;
                        r_clr_pulse <= 1'b1;
                        r_ovf       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_cnt_ce  = i_tick & w_running;
    assign o_cnt_clr = i_clr | r_clr_pulse;
    assign o_disp_q  = (r_state == LAP) ? r_hold : i_cnt_q;
    assign o_run_led = w_running;
    assign o_lap_led = (r_state == LAP);
    assign o_ovf     = r_ovf;

endmodule
